// File: rtl/dot_pkg.sv
// dot_pkg: shared types and sizing helpers for the streaming dot-product engine.
//   state_t      - FSM encoding (IDLE, ACCUM, HOLD), also exported for debug.
//   acc_width()  - accumulator width that cannot wrap for a full vector.
//   beats_width()- width of a beat counter able to hold max_beats.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no vector open
    ACCUM = 2'd1,  // vector open, partial sum in the accumulator
    HOLD  = 2'd2   // result registered, waiting for the consumer
  } state_t;

  // Each product needs 2*data_width bits. Summing lanes*max_beats of them
  // grows the magnitude by at most log2(lanes*max_beats) bits.
  function automatic int acc_width(input int lanes, input int data_width,
                                   input int max_beats);
    return 2 * data_width + $clog2(lanes * max_beats);
  endfunction

  function automatic int beats_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/dot_stream_accumulator_if.sv
// dot_stream_accumulator_if: input beat stream and output result stream of
// the dot-product engine.
//   in_*  : LANES element pairs per beat, plus last / signed-mode flags.
//   out_* : one result per vector with overflow flag and beat count.
//   slave modport  - the engine.
//   master modport - the producer/consumer side (fetch logic, write-back).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The source holds valid and its payload stable until the transfer;
// the sink may drive ready independently of valid. in_ready is allowed to
// depend combinationally on out_ready.
interface dot_stream_accumulator_if #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
);

  localparam int BW = dot_pkg::beats_width(MAX_BEATS);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a [LANES];
  logic [DATA_WIDTH-1:0] in_b [LANES];
  logic                  in_last;
  logic                  in_signed;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_ovf;
  logic [BW-1:0]         out_beats;

  modport slave (
    input  in_valid, in_a, in_b, in_last, in_signed, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_beats
  );

  modport master (
    output in_valid, in_a, in_b, in_last, in_signed, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_beats
  );

endinterface

// File: rtl/dot_lane_tree.sv
// dot_lane_tree: purely combinational beat reducer.
//   in_a, in_b : LANES operand elements (DATA_WIDTH each)
//   mode       : 1 = two's-complement operands, 0 = unsigned
//   beat_sum   : sum of the LANES products, ACC_WIDTH bits, sign-correct
//                for the selected mode
module dot_lane_tree #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 70
) (
  input  logic [DATA_WIDTH-1:0] in_a [LANES],
  input  logic [DATA_WIDTH-1:0] in_b [LANES],
  input  logic                  mode,
  output logic [ACC_WIDTH-1:0]  beat_sum
);

  localparam int PW  = 2 * DATA_WIDTH;
  localparam int LOG = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int P   = 1 << LOG;

  logic [ACC_WIDTH-1:0] ext [LANES];

  // One signed (DATA_WIDTH+1)-bit multiplier per lane serves both modes: the
  // extra top bit is the operand's sign in signed mode and zero otherwise, so
  // the product is always the true value and can simply be sign-extended.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_WIDTH:0] op_a;
    logic signed [DATA_WIDTH:0] op_b;
    logic signed [PW+1:0]       prod;

    assign op_a   = {mode & in_a[i][DATA_WIDTH-1], in_a[i]};
    assign op_b   = {mode & in_b[i][DATA_WIDTH-1], in_b[i]};
    assign prod   = op_a * op_b;
    assign ext[i] = {{(ACC_WIDTH-PW-2){prod[PW+1]}}, prod};
  end

  // Balanced tree: leaves padded to a power of two, each level halves the
  // live node count in place (node[j] reads 2j and 2j+1 before they are
  // overwritten).
  logic [ACC_WIDTH-1:0] node [P];

  always_comb begin
    for (int i = 0; i < P; i++) node[i] = '0;
    for (int i = 0; i < LANES; i++) node[i] = ext[i];
    for (int lv = 0; lv < LOG; lv++) begin
      for (int j = 0; j < P / 2; j++) begin
        if (j < (P >> (lv + 1))) node[j] = node[2*j] + node[2*j+1];
      end
    end
    beat_sum = node[0];
  end

endmodule

// File: rtl/dot_stream_accumulator.sv
// dot_stream_accumulator: streaming multi-lane dot product.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : dot_stream_accumulator_if.slave - beat input stream
//                (in_valid/in_ready/in_a/in_b/in_last/in_signed) and result
//                output stream (out_valid/out_ready/out_result/out_ovf/
//                out_beats)
//   dbg_state  : current FSM state
// A vector closes on an accepted beat with in_last, or on the MAX_BEATS-th
// beat. The result appears one cycle later and is held until consumed.
// Build option DOT_SATURATE_EN: clamp out_result on overflow instead of
// returning the low DATA_WIDTH bits.
module dot_stream_accumulator
  import dot_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16,
  parameter int ACC_WIDTH  = acc_width(LANES, DATA_WIDTH, MAX_BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dot_stream_accumulator_if.slave bus,
  output state_t                  dbg_state
);

  localparam int BW = beats_width(MAX_BEATS);

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_next, beat_sum;
  logic [BW-1:0]         cnt_q, cnt_next;
  logic                  mode_q, mode_eff;
  logic                  first, accept, close;

  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ovf_q, ovf_d;
  logic [BW-1:0]         beats_q;

  // Upper accumulator slices used for overflow detection.
  logic [ACC_WIDTH-DATA_WIDTH-1:0] hi_u;  // must be zero for unsigned fit
  logic [ACC_WIDTH-DATA_WIDTH:0]   hi_s;  // must be all-equal for signed fit

  // While a result is held, a new beat may only enter if the result leaves
  // in the same cycle; this is what sustains one vector per cycle.
  assign bus.in_ready = (state_q != HOLD) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Any beat accepted outside ACCUM opens a new vector.
  assign first    = (state_q != ACCUM);
  assign mode_eff = first ? bus.in_signed : mode_q;
  assign acc_next = (first ? '0 : acc_q) + beat_sum;
  assign cnt_next = first ? BW'(1) : cnt_q + BW'(1);
  assign close    = bus.in_last || (cnt_next == BW'(MAX_BEATS));

  dot_lane_tree #(
    .LANES      (LANES),
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_tree (
    .in_a     (bus.in_a),
    .in_b     (bus.in_b),
    .mode     (mode_eff),
    .beat_sum (beat_sum)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) state_d = close ? HOLD : ACCUM;
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (accept) state_d = close ? HOLD : ACCUM;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result formation from the sum that includes the closing beat.
  always_comb begin
    hi_u  = acc_next[ACC_WIDTH-1:DATA_WIDTH];
    hi_s  = acc_next[ACC_WIDTH-1:DATA_WIDTH-1];
    ovf_d = mode_eff ? !((&hi_s) || (~|hi_s)) : (|hi_u);
    res_d = acc_next[DATA_WIDTH-1:0];
`ifdef DOT_SATURATE_EN
    if (ovf_d) begin
      if (mode_eff) begin
        res_d = acc_next[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        res_d = '1;
      end
    end
`endif
  end

  // Accumulator, beat counter, latched mode and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      beats_q <= '0;
    end else if (accept) begin
      acc_q <= acc_next;
      cnt_q <= cnt_next;
      if (first) mode_q <= bus.in_signed;
      if (close) begin
        res_q   <= res_d;
        ovf_q   <= ovf_d;
        beats_q <= cnt_next;
      end
    end
  end

  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_result = res_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.out_beats  = beats_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_dot_stream_accumulator.sv
// tb_dot_stream_accumulator: directed table, hand sequences and randomized
// vectors checked against an arithmetic reference model via an expected queue.
module tb_dot_stream_accumulator;
  import dot_pkg::*;

  localparam int L  = 4;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int BW = beats_width(MB);
  localparam int RW = 1 + BW + DW;

  typedef logic [L-1:0][DW-1:0] lanes_t;

  typedef struct packed {
    lanes_t          a;
    lanes_t          b;
    logic            sgn;
    logic [DW-1:0]   res;
    logic            ovf;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  dot_stream_accumulator_if #(.LANES(L), .DATA_WIDTH(DW), .MAX_BEATS(MB)) bus ();

  dot_stream_accumulator #(.LANES(L), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [RW-1:0] exp_q[$];
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compares a result on the cycle before it is consumed.
  task automatic monitor();
    logic [RW-1:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none",
                 {bus.out_ovf, bus.out_beats, bus.out_result});
      end else begin
        e = exp_q.pop_front();
        check("result_record", 64'({bus.out_ovf, bus.out_beats, bus.out_result}),
              64'(e));
      end
    end
  endtask

  // One clock: sample before the edge, then update out_ready after it.
  task automatic tick(output bit took);
    @(negedge clk);
    took = rst_n && bus.in_valid && bus.in_ready;
    monitor();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    bit t;
    for (int i = 0; i < n; i++) tick(t);
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input lanes_t a, input lanes_t b, input logic last,
                           input logic sgn);
    bit took;
    int n;
    n = 0;
    for (int i = 0; i < L; i++) begin
      bus.in_a[i] = a[i];
      bus.in_b[i] = b[i];
    end
    bus.in_last   = last;
    bus.in_signed = sgn;
    bus.in_valid  = 1'b1;
    do begin
      tick(took);
      n++;
    end while (!took && n < 1000);
    if (!took) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout actual=no_handshake required=handshake");
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    bit t;
    n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 200) begin
      tick(t);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- reference model ----------------
  function automatic lanes_t mk(input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
    lanes_t r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  function automatic logic signed [127:0] beat_val(input lanes_t a,
                                                   input lanes_t b,
                                                   input logic s);
    logic signed [127:0] t, ea, eb;
    t = '0;
    for (int i = 0; i < L; i++) begin
      ea = {{96{s & a[i][31]}}, a[i]};
      eb = {{96{s & b[i][31]}}, b[i]};
      t  = t + ea * eb;
    end
    return t;
  endfunction

  function automatic logic [RW-1:0] expect_of(input logic signed [127:0] s,
                                              input logic sgn, input int beats);
    logic signed [127:0] smin, smax, umax;
    logic                ovf;
    logic [DW-1:0]       res;
    smin = -128'sd2147483648;
    smax = 128'sd2147483647;
    umax = 128'sd4294967295;
    ovf  = sgn ? ((s < smin) || (s > smax)) : (s > umax);
    res  = s[31:0];
`ifdef DOT_SATURATE_EN
    if (ovf) res = sgn ? ((s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'hFFFF_FFFF;
`endif
    return {ovf, BW'(beats), res};
  endfunction

  function automatic logic [31:0] rnd_elem();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'($urandom_range(0, 50));
      2:       return 32'd0 - 32'($urandom_range(1, 50));
      default: return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endcase
  endfunction

  // ---------------- test ----------------
  vec_t tbl [9];

  initial begin : main
    lanes_t              ra, rb;
    logic signed [127:0] msum;
    logic                msgn, lastf;
    int                  len;

    // Directed single-beat table: {a, b, signed, result, ovf}.
    tbl[0] = '{mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b0, 32'd70, 1'b0};
    tbl[1] = '{mk(32'hFFFF_FFFD, 0, 0, 0), mk(5, 0, 0, 0), 1'b1, 32'hFFFF_FFF1, 1'b0};
`ifdef DOT_SATURATE_EN
    tbl[2] = '{mk(32'hFFFF_FFFD, 0, 0, 0), mk(5, 0, 0, 0), 1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[3] = '{mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
               mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
               1'b1, 32'h7FFF_FFFF, 1'b1};
    tbl[7] = '{mk(32'h7FFF_FFFF, 1, 0, 0), mk(1, 1, 0, 0), 1'b1, 32'h7FFF_FFFF, 1'b1};
    tbl[8] = '{mk(32'hFFFF_FFFF, 1, 0, 0), mk(1, 1, 0, 0), 1'b0, 32'hFFFF_FFFF, 1'b1};
`else
    tbl[2] = '{mk(32'hFFFF_FFFD, 0, 0, 0), mk(5, 0, 0, 0), 1'b0, 32'hFFFF_FFF1, 1'b1};
    tbl[3] = '{mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
               mk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000),
               1'b1, 32'h0, 1'b1};
    tbl[7] = '{mk(32'h7FFF_FFFF, 1, 0, 0), mk(1, 1, 0, 0), 1'b1, 32'h8000_0000, 1'b1};
    tbl[8] = '{mk(32'hFFFF_FFFF, 1, 0, 0), mk(1, 1, 0, 0), 1'b0, 32'h0, 1'b1};
`endif
    tbl[4] = '{mk(1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE), mk(10, 10, 10, 10), 1'b1, 32'd0, 1'b0};
    tbl[5] = '{mk(32'hFFFF_FFFF, 0, 0, 0), mk(32'hFFFF_FFFF, 0, 0, 0), 1'b1, 32'd1, 1'b0};
    tbl[6] = '{mk(32'h8000_0000, 0, 0, 0), mk(1, 0, 0, 0), 1'b1, 32'h8000_0000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < L; i++) begin
      bus.in_a[i] = '0;
      bus.in_b[i] = '0;
    end

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    check("rst_out_beats", 64'(bus.out_beats), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    idle(2);

    // Table: every single-beat vector must show out_valid the cycle after.
    for (int i = 0; i < 9; i++) begin
      send_beat(tbl[i].a, tbl[i].b, 1'b1, tbl[i].sgn);
      check("latency_out_valid", 64'(bus.out_valid), 64'd1);
      exp_q.push_back({tbl[i].ovf, BW'(1), tbl[i].res});
    end
    drain();

    // Two beats; in_signed on the second beat must be ignored.
    send_beat(mk(1, 1, 1, 1), mk(2, 2, 2, 2), 1'b0, 1'b0);
    check("accum_state", 64'(dbg_state), 64'(ACCUM));
    idle(2);
    send_beat(mk(3, 3, 3, 3), mk(4, 4, 4, 4), 1'b1, 1'b1);
    exp_q.push_back({1'b0, BW'(2), 32'd56});
    drain();

    // Forced close at MAX_BEATS, then a separate single-beat vector.
    for (int k = 0; k < MB; k++) send_beat(mk(1, 1, 1, 1), mk(1, 1, 1, 1), 1'b0, 1'b0);
    check("maxbeats_close", 64'(bus.out_valid), 64'd1);
    exp_q.push_back({1'b0, BW'(16), 32'd64});
    send_beat(mk(1, 1, 1, 1), mk(1, 1, 1, 1), 1'b1, 1'b0);
    exp_q.push_back({1'b0, BW'(1), 32'd4});
    drain();

    // Backpressure: result held, input stalled, then simultaneous handshakes.
    bus.out_ready = 1'b0;
    send_beat(mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b1, 1'b0);
    exp_q.push_back({1'b0, BW'(1), 32'd70});
    for (int c = 0; c < 5; c++) begin
      idle(1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold", 64'({bus.out_valid, bus.out_ovf, bus.out_beats, bus.out_result}),
            64'({1'b1, 1'b0, BW'(1), 32'd70}));
    end
    bus.out_ready = 1'b1;
    send_beat(mk(1, 0, 0, 0), mk(9, 0, 0, 0), 1'b1, 1'b0);
    exp_q.push_back({1'b0, BW'(1), 32'd9});
    check("bp_back_to_back", 64'({bus.out_valid, bus.out_result}), 64'({1'b1, 32'd9}));
    check("bp_pending", 64'(exp_q.size()), 64'd1);
    drain();
    idle(1);
    check("idle_after_drain", 64'(dbg_state), 64'(IDLE));

    // Reset mid-vector discards the partial sum.
    for (int k = 0; k < 3; k++) send_beat(mk(1, 1, 1, 1), mk(1, 1, 1, 1), 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_outputs", 64'({bus.out_valid, bus.out_ovf, bus.out_beats, bus.out_result}),
          64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    idle(2);
    rst_n = 1'b1;
    send_beat(mk(2, 0, 0, 0), mk(3, 0, 0, 0), 1'b1, 1'b0);
    exp_q.push_back({1'b0, BW'(1), 32'd6});
    drain();

    // Randomized vectors with gaps, random out_ready and stray in_signed.
    rand_rdy = 1'b1;
    for (int v = 0; v < 60; v++) begin
      len   = $urandom_range(1, MB);
      lastf = (len < MB) ? 1'b1 : 1'($urandom_range(0, 1));
      msgn  = 1'($urandom_range(0, 1));
      msum  = '0;
      for (int k = 0; k < len; k++) begin
        for (int i = 0; i < L; i++) begin
          ra[i] = rnd_elem();
          rb[i] = rnd_elem();
        end
        msum = msum + beat_val(ra, rb, msgn);
        idle($urandom_range(0, 2));
        send_beat(ra, rb, (k == len - 1) ? lastf : 1'b0,
                  (k == 0) ? msgn : 1'($urandom_range(0, 1)));
      end
      exp_q.push_back(expect_of(msum, msgn, len));
    end
    rand_rdy = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
